input_pixel_buffer: RTL and testbench
=====================================

# input_pixel_buffer

Parametrised tile input buffer for the rotate engine, the next generation of the core's pixel input memory. It accepts LANES-byte words over a valid/ready handshake, each byte carrying its own target address, and tracks which bytes of the current tile have been written. It serves CHANNELS independent registered read ports with same-cycle write forwarding, per-port padding and unwritten-byte padding. It sits between the AHB read-data path and the pixel rotate core.

## Interface
- DEPTH, 192: buffer size in bytes.
- LANES, 4: bytes per write word.
- CHANNELS, 3: number of read ports (B, G, R, ...).
- AW, 8: byte address width; DEPTH <= 2**AW.
- PAD_VALUE, 8'h00: byte returned for padded, unwritten or out-of-range reads.
- CW, derived $clog2(DEPTH+1): count width.

Ports:
- I_IBUF_HCLK  in  1  clock, rising edge.
- I_IBUF_HRESET_N  in  1  reset; one clock; reset is asynchronous and active-low.
- I_IBUF_START  in  1  begin new tile; clears valid bits and count.
- I_IBUF_WVALID  in  1  write word valid.
- O_IBUF_WREADY  out  1  buffer accepts writes.
- I_IBUF_WDATA  in  8*LANES  write bytes; lane k = [8k+7:8k].
- I_IBUF_WADDR  in  AW*LANES  per-lane byte address; lane k = [AW*k+AW-1:AW*k].
- I_IBUF_WBE  in  LANES  per-lane byte enable.
- I_IBUF_RVALID  in  1  read request, all ports.
- I_IBUF_RADDR  in  AW*CHANNELS  per-port read address.
- I_IBUF_RPAD  in  CHANNELS  per-port force-pad.
- O_IBUF_RDATA  out  8*CHANNELS  per-port read byte.
- O_IBUF_RDVALID  out  1  RDATA valid.
- O_IBUF_COUNT  out  CW  number of distinct bytes written this tile.
- O_IBUF_FULL  out  1  COUNT == DEPTH.

## Operation
- The FSM has three states: IDLE, FILL and FULL. Reset places it in IDLE.
- START in any state: next state FILL, every valid bit cleared, COUNT <= 0. START overrides a same-cycle write, which is dropped.
- FILL: WREADY=1. A write fires on WVALID&&WREADY. For each lane k with WBE[k]=1 and WADDR_k < DEPTH:
  - mem[WADDR_k] <= WDATA_k;
  - valid[WADDR_k] <= 1.
- Lanes with an address >= DEPTH are dropped silently.
- Duplicate addresses within one word: the highest-index lane wins.
- COUNT increases by the number of distinct addresses that were previously invalid. Rewrites of already-valid bytes update data but not COUNT.
- FILL -> FULL when the next COUNT equals DEPTH.
- FULL: WREADY=0 and writes are ignored. The buffer stays in FULL until START.
- IDLE: WREADY=0 and reads return PAD_VALUE (all bytes are invalid).
- Read, port c, on RVALID. Priority, first match wins:
  1. START this cycle, or RPAD[c], or RADDR_c >= DEPTH -> PAD_VALUE.
  2. A firing write lane whose address equals RADDR_c -> that lane's byte; if several lanes match, the highest index wins (forwarding).
  3. valid[RADDR_c] -> mem[RADDR_c].
  4. Otherwise -> PAD_VALUE.
- When RVALID=0, RDATA holds its previous value.
- Memory array contents are not reset. Only the valid bits, FSM, COUNT, RDATA and RDVALID are reset.

## Timing
- Reset values: WREADY=0, RDATA=0, RDVALID=0, COUNT=0, FULL=0, state IDLE, all valid bits 0.
- Assertion of reset mid-tile aborts immediately; the next START is required.
- WREADY is a registered-state decode (no combinational path from WVALID).
- Write data is visible to a non-forwarded read in the cycle after acceptance.
- COUNT and FULL update on the edge that accepts the write.
- WREADY falls in the same cycle FULL rises.
- Read latency is 1: RDATA and RDVALID are registered on the edge after RVALID.
- RDVALID = RVALID delayed one cycle, including during START, IDLE and FULL.

## Test plan
- Reset then START:
  - Response: WREADY=1 the next cycle and COUNT=0.
  - Then read ports 0..2 at addresses 0, 5 and 191 -> RDATA=00/00/00 (unwritten), RDVALID=1 one cycle later.
- Write WADDR={3,2,1,0}, WDATA=32'hDDCCBBAA, WBE=4'hF:
  - Response: COUNT=4.
  - A next-cycle read of addresses 0, 2 and 3 -> AA, CC, DD.
  - Rewriting the same word leaves COUNT=4.
- Same-cycle forwarding:
  - Stimulus: write lane 2 to address 10 with 8'h5A while port 1 reads address 10.
  - Response: port 1 returns 5A.
  - Duplicate: lanes 0 and 3 both to address 20 with 11/44 -> a later read returns 44 and COUNT rises by 1.
- Pad and range:
  - RPAD=3'b100 on valid address 0 -> port 2 returns 00 while ports 0 and 1 return AA.
  - Read of address 200 -> 00.
  - A lane write to address 195 is dropped and COUNT is unchanged.
- Fill:
  - Stimulus: 48 words covering addresses 0..191.
  - Response: FULL=1 and WREADY=0 on the last acceptance edge, COUNT=192.
  - A further WVALID has no effect.
  - START -> FULL=0, COUNT=0, and a read of address 0 returns 00.
- Corner events:
  - START coincident with WVALID in FILL -> the write is dropped and COUNT=0.
  - Asynchronous reset asserted mid-fill -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/input_pixel_buffer.sv
// Tile input buffer for the rotate engine: per-lane addressed byte writes, per-byte
// valid tracking, and CHANNELS registered read ports with write forwarding and padding.
module input_pixel_buffer #(
   parameter int          DEPTH     = 192,
   parameter int          LANES     = 4,
   parameter int          CHANNELS  = 3,
   parameter int          AW        = 8,
   parameter logic [7:0]  PAD_VALUE = 8'h00,
   parameter int          CW        = $clog2(DEPTH + 1)
) (
   input  logic                    I_IBUF_HCLK,
   input  logic                    I_IBUF_HRESET_N,
   input  logic                    I_IBUF_START,
   input  logic                    I_IBUF_WVALID,
   output logic                    O_IBUF_WREADY,
   input  logic [8*LANES-1:0]      I_IBUF_WDATA,
   input  logic [AW*LANES-1:0]     I_IBUF_WADDR,
   input  logic [LANES-1:0]        I_IBUF_WBE,
   input  logic                    I_IBUF_RVALID,
   input  logic [AW*CHANNELS-1:0]  I_IBUF_RADDR,
   input  logic [CHANNELS-1:0]     I_IBUF_RPAD,
   output logic [8*CHANNELS-1:0]   O_IBUF_RDATA,
   output logic                    O_IBUF_RDVALID,
   output logic [CW-1:0]           O_IBUF_COUNT,
   output logic                    O_IBUF_FULL,
   output logic [1:0]              O_IBUF_STATE
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           new_cnt;
   logic [DEPTH-1:0]        valid_q;
   logic [7:0]              mem_q [DEPTH];
   logic [8*CHANNELS-1:0]   rdata_q, rdata_d;
   logic                    rdvalid_q;

   logic [AW-1:0]           waddr [LANES];
   logic [7:0]              wbyte [LANES];
   logic [AW-1:0]           raddr [CHANNELS];
   logic [LANES-1:0]        lane_en;
   logic [LANES-1:0]        lane_win;
   logic                    wr_fire;

   // Handshake: a word is accepted on a rising edge where WVALID && WREADY; WREADY
   // depends only on registered state, and a same-cycle START discards the word.
   assign wr_fire = I_IBUF_WVALID && (state_q == ST_FILL) && !I_IBUF_START;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         waddr[k]   = I_IBUF_WADDR[AW*k +: AW];
         wbyte[k]   = I_IBUF_WDATA[8*k +: 8];
         lane_en[k] = wr_fire && I_IBUF_WBE[k] && (32'(waddr[k]) < DEPTH);
      end
      for (int c = 0; c < CHANNELS; c++) begin
         raddr[c] = I_IBUF_RADDR[AW*c +: AW];
      end
   end

   // A lane only counts towards COUNT if no higher lane targets the same byte.
   always_comb begin
      lane_win = lane_en;
      new_cnt  = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int j = k + 1; j < LANES; j++) begin
            if (lane_en[j] && (waddr[j] == waddr[k])) lane_win[k] = 1'b0;
         end
         if (lane_win[k] && !valid_q[waddr[k]]) new_cnt = new_cnt + CW'(1);
      end
   end

   always_comb begin
      count_d = count_q + new_cnt;
      state_d = state_q;
      if (I_IBUF_START) begin
         count_d = '0;
         state_d = ST_FILL;
      end else if ((state_q == ST_FILL) && (count_d == CW'(DEPTH))) begin
         state_d = ST_FULL;
      end
   end

   // Forwarded lanes override stored data; ascending loop lets the highest lane win.
   always_comb begin
      rdata_d = rdata_q;
      if (I_IBUF_RVALID) begin
         for (int c = 0; c < CHANNELS; c++) begin
            rdata_d[8*c +: 8] = PAD_VALUE;
            if (!I_IBUF_START && !I_IBUF_RPAD[c] && (32'(raddr[c]) < DEPTH)) begin
               if (valid_q[raddr[c]]) rdata_d[8*c +: 8] = mem_q[raddr[c]];
               for (int k = 0; k < LANES; k++) begin
                  if (lane_en[k] && (waddr[k] == raddr[c])) rdata_d[8*c +: 8] = wbyte[k];
               end
            end
         end
      end
   end

   always_ff @(posedge I_IBUF_HCLK or negedge I_IBUF_HRESET_N) begin
      if (!I_IBUF_HRESET_N) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         valid_q   <= '0;
         rdata_q   <= '0;
         rdvalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rdata_q   <= rdata_d;
         rdvalid_q <= I_IBUF_RVALID;
         if (I_IBUF_START) begin
            valid_q <= '0;
         end else begin
            for (int k = 0; k < LANES; k++) begin
               if (lane_en[k]) valid_q[waddr[k]] <= 1'b1;
            end
         end
      end
   end

   // Storage has no reset; the valid bits alone decide what is readable.
   always_ff @(posedge I_IBUF_HCLK) begin
      for (int k = 0; k < LANES; k++) begin
         if (lane_en[k]) mem_q[waddr[k]] <= wbyte[k];
      end
   end

   assign O_IBUF_WREADY  = (state_q == ST_FILL);
   assign O_IBUF_RDATA   = rdata_q;
   assign O_IBUF_RDVALID = rdvalid_q;
   assign O_IBUF_COUNT   = count_q;
   assign O_IBUF_FULL    = (count_q == CW'(DEPTH));
   assign O_IBUF_STATE   = state_q;

endmodule

// File: tb/tb_input_pixel_buffer.sv
// Directed bench for input_pixel_buffer: fill, forwarding, padding, range, START and reset.
module tb_input_pixel_buffer;

   localparam int DEPTH = 192;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          wvalid;
   logic          wready;
   logic [31:0]   wdata;
   logic [31:0]   waddr;
   logic [3:0]    wbe;
   logic          rvalid;
   logic [23:0]   raddr;
   logic [2:0]    rpad;
   logic [23:0]   rdata;
   logic          rdvalid;
   logic [CW-1:0] count;
   logic          full;
   logic [1:0]    state;

   int n_vec;
   int n_err;

   input_pixel_buffer dut (
      .I_IBUF_HCLK     (clk),
      .I_IBUF_HRESET_N (rst_n),
      .I_IBUF_START    (start),
      .I_IBUF_WVALID   (wvalid),
      .O_IBUF_WREADY   (wready),
      .I_IBUF_WDATA    (wdata),
      .I_IBUF_WADDR    (waddr),
      .I_IBUF_WBE      (wbe),
      .I_IBUF_RVALID   (rvalid),
      .I_IBUF_RADDR    (raddr),
      .I_IBUF_RPAD     (rpad),
      .O_IBUF_RDATA    (rdata),
      .O_IBUF_RDVALID  (rdvalid),
      .O_IBUF_COUNT    (count),
      .O_IBUF_FULL     (full),
      .O_IBUF_STATE    (state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // drivers: inputs change on the falling edge, results are sampled one falling edge later
   task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      wvalid = 1'b1; waddr = a; wdata = d; wbe = be;
      @(negedge clk);
      wvalid = 1'b0; wbe = 4'h0;
   endtask

   task automatic read3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [2:0] pad);
      rvalid = 1'b1; raddr = {a2, a1, a0}; rpad = pad;
      @(negedge clk);
      rvalid = 1'b0; rpad = 3'b000;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  b;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; wvalid = 1'b0; wdata = '0; waddr = '0; wbe = '0;
      rvalid = 1'b0; raddr = '0; rpad = '0;
      repeat (2) @(negedge clk);
      check_val("rst_wready", 32'(wready), 32'd0);
      check_val("rst_rdata", 32'(rdata), 32'd0);
      check_val("rst_rdvalid", 32'(rdvalid), 32'd0);
      check_val("rst_count", 32'(count), 32'd0);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("idle_wready", 32'(wready), 32'd0);

      do_start();
      check_val("start_wready", 32'(wready), 32'd1);
      check_val("start_count", 32'(count), 32'd0);
      read3(8'd0, 8'd5, 8'd191, 3'b000);
      check_val("unwritten_rdata", 32'(rdata), 32'h000000);
      check_val("unwritten_rdvalid", 32'(rdvalid), 32'd1);
      @(negedge clk);
      check_val("rdvalid_drop", 32'(rdvalid), 32'd0);

      write_word({8'd3, 8'd2, 8'd1, 8'd0}, 32'hDDCCBBAA, 4'hF);
      check_val("word_count", 32'(count), 32'd4);
      read3(8'd0, 8'd2, 8'd3, 3'b000);
      check_val("word_read", 32'(rdata), 32'hDDCCAA);
      @(negedge clk);
      check_val("rdata_hold", 32'(rdata), 32'hDDCCAA);
      write_word({8'd3, 8'd2, 8'd1, 8'd0}, 32'hDDCCBBAA, 4'hF);
      check_val("rewrite_count", 32'(count), 32'd4);

      // write lane 2 and read port 1 at the same address in the same cycle
      wvalid = 1'b1; waddr = {8'd0, 8'd10, 8'd0, 8'd0}; wdata = 32'h005A0000; wbe = 4'b0100;
      rvalid = 1'b1; raddr = {8'd11, 8'd10, 8'd0};
      @(negedge clk);
      wvalid = 1'b0; wbe = 4'h0; rvalid = 1'b0;
      check_val("fwd_rdata", 32'(rdata), 32'h005AAA);
      check_val("fwd_count", 32'(count), 32'd5);

      write_word({8'd20, 8'd0, 8'd0, 8'd20}, 32'h44000011, 4'b1001);
      check_val("dup_count", 32'(count), 32'd6);
      read3(8'd20, 8'd20, 8'd20, 3'b000);
      check_val("dup_read", 32'(rdata), 32'h444444);

      read3(8'd0, 8'd0, 8'd0, 3'b100);
      check_val("rpad_read", 32'(rdata), 32'h00AAAA);
      read3(8'd200, 8'd2, 8'd10, 3'b000);
      check_val("range_read", 32'(rdata), 32'h5ACC00);
      write_word({8'd0, 8'd0, 8'd0, 8'd195}, 32'h000000EE, 4'b0001);
      check_val("range_write_count", 32'(count), 32'd6);

      for (int w = 0; w < 48; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(4 * w + k);
            a[8*k +: 8] = b;
            d[8*k +: 8] = b ^ 8'h5A;
         end
         if (w == 47) check_val("prefull_wready", 32'(wready), 32'd1);
         write_word(a, d, 4'hF);
      end
      check_val("fill_count", 32'(count), 32'd192);
      check_val("fill_full", 32'(full), 32'd1);
      check_val("fill_wready", 32'(wready), 32'd0);
      check_val("fill_state", 32'(state), 32'd2);
      write_word({8'd3, 8'd2, 8'd1, 8'd0}, 32'hFFFFFFFF, 4'hF);
      check_val("full_write_count", 32'(count), 32'd192);
      read3(8'd0, 8'd191, 8'd100, 3'b000);
      check_val("full_read", 32'(rdata), 32'h3EE55A);

      do_start();
      check_val("restart_full", 32'(full), 32'd0);
      check_val("restart_count", 32'(count), 32'd0);
      read3(8'd0, 8'd191, 8'd100, 3'b000);
      check_val("restart_read", 32'(rdata), 32'h000000);

      write_word({8'd7, 8'd6, 8'd5, 8'd4}, 32'h01020304, 4'hF);
      check_val("pre_startwr_count", 32'(count), 32'd4);
      start = 1'b1; wvalid = 1'b1; waddr = {8'd3, 8'd2, 8'd1, 8'd0}; wdata = 32'h11223344; wbe = 4'hF;
      @(negedge clk);
      start = 1'b0; wvalid = 1'b0; wbe = 4'h0;
      check_val("startwr_count", 32'(count), 32'd0);
      read3(8'd0, 8'd4, 8'd3, 3'b000);
      check_val("startwr_read", 32'(rdata), 32'h000000);

      write_word({8'd3, 8'd2, 8'd1, 8'd0}, 32'hDDCCBBAA, 4'hF);
      read3(8'd0, 8'd1, 8'd2, 3'b000);
      check_val("pre_reset_rdata", 32'(rdata), 32'hCCBBAA);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rdata", 32'(rdata), 32'd0);
      check_val("async_rdvalid", 32'(rdvalid), 32'd0);
      check_val("async_count", 32'(count), 32'd0);
      check_val("async_wready", 32'(wready), 32'd0);
      check_val("async_state", 32'(state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      write_word({8'd3, 8'd2, 8'd1, 8'd0}, 32'hDDCCBBAA, 4'hF);
      check_val("idle_write_count", 32'(count), 32'd0);
      read3(8'd0, 8'd1, 8'd2, 3'b000);
      check_val("idle_read", 32'(rdata), 32'h000000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
